// File: rtl/mem_port_arbiter.sv
// Shares one handshaked single-port memory between fetch and data requesters.
// Tracks one outstanding transaction; data wins ties unless data went last.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_kill,
   output logic [DW-1:0] i_rdata,
   output logic          i_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          stall_i,
   output logic          stall_d,
   output logic          mem_req,
   output logic          mem_we,
   output logic [2:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, I_REQ, I_RESP, D_REQ, D_RESP, I_DROP
   } state_t;

   state_t        state, stateNxt;
   logic          lastD, lastDNxt;
   logic          reqNxt, weNxt;
   logic [2:0]    sizeNxt;
   logic [AW-1:0] addrNxt;
   logic [DW-1:0] wdataNxt, iRdataNxt, dRdataNxt;
   logic          iValidNxt, dValidNxt;
   logic          iPend, dPend, grantI, grantD;

   assign stall_i = i_req & ~i_valid & ~i_kill;
   assign stall_d = d_req & ~d_valid;

   // A requester in its valid cycle still holds req for the finished access
   assign iPend  = i_req & ~i_kill & ~i_valid;
   assign dPend  = d_req & ~i_kill & ~d_valid;
   assign grantI = iPend & (~dPend | lastD);
   assign grantD = dPend & ~grantI;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lastD     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_size  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         i_valid   <= 1'b0;
         d_rdata   <= '0;
         d_valid   <= 1'b0;
      end else begin
         state     <= stateNxt;
         lastD     <= lastDNxt;
         mem_req   <= reqNxt;
         mem_we    <= weNxt;
         mem_size  <= sizeNxt;
         mem_addr  <= addrNxt;
         mem_wdata <= wdataNxt;
         i_rdata   <= iRdataNxt;
         i_valid   <= iValidNxt;
         d_rdata   <= dRdataNxt;
         d_valid   <= dValidNxt;
      end
   end

   always_comb begin
      stateNxt  = state;
      lastDNxt  = lastD;
      reqNxt    = mem_req;
      weNxt     = mem_we;
      sizeNxt   = mem_size;
      addrNxt   = mem_addr;
      wdataNxt  = mem_wdata;
      iRdataNxt = i_rdata;
      dRdataNxt = d_rdata;
      iValidNxt = 1'b0;
      dValidNxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (grantI) begin
               stateNxt = I_REQ;
               lastDNxt = 1'b0;
               reqNxt   = 1'b1;
               weNxt    = 1'b0;
               sizeNxt  = 3'b010;
               addrNxt  = i_addr;
               wdataNxt = '0;
            end else if (grantD) begin
               stateNxt = D_REQ;
               lastDNxt = 1'b1;
               reqNxt   = 1'b1;
               weNxt    = d_we;
               sizeNxt  = d_size;
               addrNxt  = d_addr;
               wdataNxt = d_wdata;
            end
         end
         I_REQ: begin
            if (i_kill) begin
               reqNxt   = 1'b0;
               stateNxt = mem_ready ? I_DROP : IDLE;
            end else if (mem_ready) begin
               reqNxt   = 1'b0;
               stateNxt = I_RESP;
            end
         end
         I_RESP: begin
            if (mem_rvalid) begin
               stateNxt = IDLE;
               if (!i_kill) begin
                  iRdataNxt = mem_rdata;
                  iValidNxt = 1'b1;
               end
            end else if (i_kill) begin
               stateNxt = I_DROP;
            end
         end
         D_REQ: begin
            if (mem_ready) begin
               reqNxt   = 1'b0;
               stateNxt = D_RESP;
            end
         end
         D_RESP: begin
            if (mem_rvalid) begin
               dRdataNxt = mem_rdata;
               dValidNxt = 1'b1;
               stateNxt  = IDLE;
            end
         end
         I_DROP: begin
            if (mem_rvalid) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a hand-driven memory, one step per
// cycle, outputs checked #3 after each rising edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_kill, i_valid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_valid;
   logic [2:0]  d_size;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        stall_i, stall_d;
   logic        mem_req, mem_we, mem_ready, mem_rvalid;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   mem_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
      .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_size(d_size),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .stall_i(stall_i), .stall_d(stall_d),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic allZero(input string tag);
      chk({tag, ".mem_req"}, 32'(mem_req), 32'h0);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, ".mem_size"}, 32'(mem_size), 32'h0);
      chk({tag, ".mem_addr"}, mem_addr, 32'h0);
      chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, ".i_rdata"}, i_rdata, 32'h0);
      chk({tag, ".i_valid"}, 32'(i_valid), 32'h0);
      chk({tag, ".d_rdata"}, d_rdata, 32'h0);
      chk({tag, ".d_valid"}, 32'(d_valid), 32'h0);
   endtask

   initial begin
      reset = 1'b0; i_req = 0; i_addr = 0; i_kill = 0;
      d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      #3;
      allZero("reset");
      #9 reset = 1'b1;

      // single fetch
      cyc();
      i_req = 1; i_addr = 32'h100; mem_ready = 1; #1;
      chk("sf.c0.stall_i", 32'(stall_i), 32'h1);
      chk("sf.c0.mem_req", 32'(mem_req), 32'h0);
      cyc(); #1;
      chk("sf.c1.mem_req", 32'(mem_req), 32'h1);
      chk("sf.c1.mem_addr", mem_addr, 32'h100);
      chk("sf.c1.mem_we", 32'(mem_we), 32'h0);
      chk("sf.c1.mem_size", 32'(mem_size), 32'h2);
      chk("sf.c1.stall_i", 32'(stall_i), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h00500093; #1;
      chk("sf.c2.mem_req", 32'(mem_req), 32'h0);
      chk("sf.c2.stall_i", 32'(stall_i), 32'h1);
      cyc();
      mem_rvalid = 0; #1;
      chk("sf.c3.i_valid", 32'(i_valid), 32'h1);
      chk("sf.c3.i_rdata", i_rdata, 32'h00500093);
      chk("sf.c3.stall_i", 32'(stall_i), 32'h0);
      i_req = 0;
      cyc(); #1;
      chk("sf.c4.i_valid", 32'(i_valid), 32'h0);
      chk("sf.c4.mem_req", 32'(mem_req), 32'h0);

      // simultaneous requests from reset
      reset = 0; #1;
      allZero("rst2");
      reset = 1;
      cyc();
      i_req = 1; i_addr = 32'h104;
      d_req = 1; d_we = 1; d_size = 3'b010;
      d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; mem_ready = 1; #1;
      chk("sim.c0.stall_d", 32'(stall_d), 32'h1);
      cyc(); #1;
      chk("sim.c1.mem_addr", mem_addr, 32'h2000);
      chk("sim.c1.mem_we", 32'(mem_we), 32'h1);
      chk("sim.c1.mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sim.c1.mem_req", 32'(mem_req), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h0; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("sim.c3.d_valid", 32'(d_valid), 32'h1);
      chk("sim.c3.stall_d", 32'(stall_d), 32'h0);
      chk("sim.c3.stall_i", 32'(stall_i), 32'h1);
      d_req = 0; d_we = 0;
      cyc(); #1;
      chk("sim.c4.mem_addr", mem_addr, 32'h104);
      chk("sim.c4.mem_we", 32'(mem_we), 32'h0);
      chk("sim.c4.mem_req", 32'(mem_req), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h13; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("sim.c6.i_valid", 32'(i_valid), 32'h1);
      chk("sim.c6.i_rdata", i_rdata, 32'h13);
      i_req = 0;
      cyc();

      // fairness: data, fetch, data
      d_req = 1; d_we = 0; d_addr = 32'h2004;
      i_req = 1; i_addr = 32'h108; #1;
      cyc(); #1;
      chk("fair.d1.mem_addr", mem_addr, 32'h2004);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'hAAAA0001; #1;
      cyc();
      mem_rvalid = 0; d_addr = 32'h2008; #1;
      chk("fair.d1.d_rdata", d_rdata, 32'hAAAA0001);
      chk("fair.d1.d_valid", 32'(d_valid), 32'h1);
      cyc(); #1;
      chk("fair.i.mem_addr", mem_addr, 32'h108);
      chk("fair.i.mem_we", 32'(mem_we), 32'h0);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h13; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("fair.i.i_valid", 32'(i_valid), 32'h1);
      i_req = 0;
      cyc(); #1;
      chk("fair.d2.mem_addr", mem_addr, 32'h2008);
      chk("fair.d2.mem_req", 32'(mem_req), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'hBBBB0002; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("fair.d2.d_rdata", d_rdata, 32'hBBBB0002);
      d_req = 0;
      cyc();

      // kill in I_REQ without ready; lastD=1 so fetch wins the tie
      i_req = 1; i_addr = 32'h180;
      d_req = 1; d_we = 1; d_addr = 32'h3004; d_wdata = 32'h55;
      mem_ready = 0; #1;
      cyc(); #1;
      chk("kreq.mem_addr", mem_addr, 32'h180);
      chk("kreq.mem_req", 32'(mem_req), 32'h1);
      i_kill = 1; #1;
      chk("kreq.stall_i", 32'(stall_i), 32'h0);
      chk("kreq.stall_d", 32'(stall_d), 32'h1);
      cyc();
      i_kill = 0; i_req = 0; #1;
      chk("kreq.drop.mem_req", 32'(mem_req), 32'h0);
      cyc();
      mem_ready = 1; #1;
      chk("kreq.d.mem_req", 32'(mem_req), 32'h1);
      chk("kreq.d.mem_addr", mem_addr, 32'h3004);
      chk("kreq.d.mem_we", 32'(mem_we), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h99; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("kreq.d.d_valid", 32'(d_valid), 32'h1);
      d_req = 0; d_we = 0;
      cyc();

      // kill during I_RESP, response arrives two cycles later
      i_req = 1; i_addr = 32'h1C0; #1;
      cyc(); #1;
      chk("kresp.mem_addr", mem_addr, 32'h1C0);
      cyc();
      i_kill = 1; i_addr = 32'h200; #1;
      chk("kresp.stall_i", 32'(stall_i), 32'h0);
      cyc();
      i_kill = 0; #1;
      chk("kresp.w1.mem_req", 32'(mem_req), 32'h0);
      chk("kresp.w1.i_valid", 32'(i_valid), 32'h0);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0; #1;
      chk("kresp.w2.mem_req", 32'(mem_req), 32'h0);
      cyc();
      mem_rvalid = 0; #1;
      chk("kresp.w3.i_valid", 32'(i_valid), 32'h0);
      chk("kresp.w3.mem_req", 32'(mem_req), 32'h0);
      cyc(); #1;
      chk("kresp.new.mem_req", 32'(mem_req), 32'h1);
      chk("kresp.new.mem_addr", mem_addr, 32'h200);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h77; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("kresp.new.i_valid", 32'(i_valid), 32'h1);
      chk("kresp.new.i_rdata", i_rdata, 32'h77);
      i_req = 0;
      cyc();

      // reset asserted while in D_RESP
      d_req = 1; d_we = 0; d_addr = 32'h2100; #1;
      cyc(); #1;
      chk("rmid.mem_addr", mem_addr, 32'h2100);
      cyc();
      #1 reset = 0; #1;
      allZero("rmid");
      d_req = 0;
      #1 reset = 1;

      // spurious response in IDLE, then a fresh load
      cyc();
      mem_rvalid = 1; mem_rdata = 32'h12345678; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("spur.i_valid", 32'(i_valid), 32'h0);
      chk("spur.d_valid", 32'(d_valid), 32'h0);
      chk("spur.mem_req", 32'(mem_req), 32'h0);
      d_req = 1; d_we = 0; d_size = 3'b010; d_addr = 32'h3000; #1;
      cyc(); #1;
      chk("ld.mem_addr", mem_addr, 32'h3000);
      chk("ld.mem_req", 32'(mem_req), 32'h1);
      cyc();
      mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; #1;
      cyc();
      mem_rvalid = 0; #1;
      chk("ld.d_valid", 32'(d_valid), 32'h1);
      chk("ld.d_rdata", d_rdata, 32'hCAFEF00D);
      d_req = 0;
      cyc(); #1;
      chk("ld.after.d_valid", 32'(d_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, handshaked memory between the pipeline's instruction-fetch requester and its memory-stage data requester. It sits between the datapath (fetch address, memory-stage address, write data, size and write-enable) and the memory, and it tracks one outstanding transaction. It returns read data to the requester that issued the transaction and drives stall requests into the hazard unit until that requester's transaction completes. Arbitration gives data priority, except that after a data grant a waiting fetch is served first.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch wants the word at `i_addr`; held until `i_valid` or `i_kill`
- `i_addr`  in  AW  fetch address (pcF)
- `i_kill`  in  1  one-cycle pulse; cancels the pending or in-flight fetch (control change)
- `i_rdata`  out  DW  fetched instruction; valid while `i_valid`=1
- `i_valid`  out  1  one-cycle completion pulse for a fetch
- `d_req`  in  1  memory stage wants access; held until `d_valid`
- `d_we`  in  1  1=store, 0=load
- `d_size`  in  3  access size code, passed through unchanged
- `d_addr`  in  AW  data address (alu_outM)
- `d_wdata`  in  DW  store data (write_dataM)
- `d_rdata`  out  DW  load data; valid while `d_valid`=1
- `d_valid`  out  1  one-cycle completion pulse for a data access (loads and stores)
- `stall_i`  out  1  `i_req & ~i_valid & ~i_kill`; drives stallF/stallD
- `stall_d`  out  1  `d_req & ~d_valid`; freezes the whole pipeline
- `mem_req`  out  1  request to memory
- `mem_we`  out  1  write enable
- `mem_size`  out  3  size code
- `mem_addr`  out  AW  address
- `mem_wdata`  out  DW  store data
- `mem_ready`  in  1  memory accepts the request this cycle when `mem_req`=1
- `mem_rvalid`  in  1  response or completion pulse, one per accepted request
- `mem_rdata`  in  DW  read data, sampled when `mem_rvalid`=1

## Operation
- **FSM states:**
  - IDLE
  - I_REQ, I_RESP
  - D_REQ, D_RESP
  - I_DROP: the fetch was killed while its response is still owed.
- **IDLE:**
  - If both requests are pending: grant fetch when `last_d`=1, otherwise grant data.
  - If only one is pending, grant it.
  - Requests are sampled only when `i_kill`=0. The fetch is not granted in a cycle where `i_kill`=1.
  - On a grant, register addr, we, size and wdata into the mem_* outputs. Fetch grants set we=0 and size=word (3'b010).
  - Go to I_REQ or D_REQ.
  - Set `last_d` to 1 on a data grant and to 0 on a fetch grant.
- **x_REQ:**
  - `mem_req`=1 with the mem_* outputs held stable.
  - On `mem_ready`, go to x_RESP and drop `mem_req` in the next cycle.
- **x_RESP:** on `mem_rvalid`, register `mem_rdata` into `i_rdata` or `d_rdata`, pulse the matching valid next cycle, and go to IDLE.
- **`i_kill` during I_REQ:**
  - If `mem_ready` is 0 that cycle, withdraw the request and go to IDLE. No memory transaction occurs.
  - If `mem_ready` is 1 that cycle, the request is accepted; go to I_DROP.
- **`i_kill` during I_RESP:**
  - Go to I_DROP.
  - If `mem_rvalid` arrives in the same cycle, discard it and go to IDLE. `i_valid` is not pulsed.
- **I_DROP:** wait for `mem_rvalid`, discard the data, go to IDLE.
- **Ignored conditions:**
  - `mem_rvalid` in IDLE or x_REQ is ignored.
  - `i_kill` with no fetch outstanding has no effect.
- **Data accesses:** never cancelled. `d_req` is never killed.
- **Stores:** complete on `mem_rvalid` like loads. `d_rdata` is then don't-care but still registered.
- **Reset:**
  - State = IDLE, `last_d`=0.
  - All outputs = 0: `mem_req`, `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`, `i_rdata`, `i_valid`, `d_rdata`, `d_valid`.
  - `stall_i` and `stall_d` follow their inputs combinationally.
- **Reset mid-transaction:** abandon the transaction. The memory is reset by the same reset, so no stale response is expected; any that arrives is ignored in IDLE.

## Timing
- All outputs except `stall_i` and `stall_d` are registered.
- Minimum latency, request in cycle 0 with `mem_ready`=1 immediately and `mem_rvalid` one cycle after acceptance:
  - Cycle 1: `mem_req`=1.
  - Cycle 2: `mem_rvalid`.
  - Cycle 3: `x_valid`=1.
  - Result: 3 cycles from request to valid.
- Throughput: at most one transaction per 3 cycles. A new grant may be made in the cycle after `x_valid` deasserts the requester's hold. The FSM is back in IDLE during the valid cycle and may grant in that same cycle.
- Requesters must hold their address and data stable while their req is high. The arbiter samples them only at grant.

## Test plan
- **Single fetch:** `i_req`=1 with `i_addr`=0x100, memory ready immediately, rvalid a cycle later with 0x00500093 -> `mem_addr`=0x100 and `mem_we`=0 in cycle 1; `i_valid`=1 with `i_rdata`=0x00500093 in cycle 3; `stall_i` high in cycles 0-2.
- **Simultaneous requests:** fetch at 0x104 and store to 0x2000 of 0xDEADBEEF, size 3'b010, both from reset -> data is served first (`mem_we`=1, `mem_addr`=0x2000), then fetch at 0x104; `stall_d` drops before `stall_i`.
- **Fairness:** `d_req` kept high back-to-back with `i_req` pending -> grants alternate data, fetch, data; fetch is never starved beyond one data transaction.
- **Kill while waiting:** `i_kill` during I_RESP with rvalid 2 cycles later -> no `i_valid`; a new fetch at 0x200 issues only after the dropped rvalid.
- **Kill in I_REQ with `mem_ready`=0:** -> `mem_req` drops the next cycle and no rvalid is expected; a pending `d_req` is granted immediately.
- **Reset asserted in D_RESP:** -> all outputs 0 asynchronously; after release, a fresh load from 0x3000 completes normally and a spurious `mem_rvalid` in IDLE produces no valid.
